// File: rtl/ptw_stats_pkg.sv
// ptw_stats_pkg
// Shared types and helpers for the PTW statistics monitor.
//   stat_sel_e   : readout statistic encoding used on rd_stat_sel
//   chan_state_e : per-requestor walk tracking state
//   sat_add      : width-generic saturating adder (operands up to 64 bits)
package ptw_stats_pkg;

    typedef enum logic [2:0] {
        STAT_REQ     = 3'd0,
        STAT_HIT     = 3'd1,
        STAT_MISS    = 3'd2,
        STAT_AE      = 3'd3,
        STAT_LAT_SUM = 3'd4,
        STAT_LAT_MAX = 3'd5,
        STAT_VPN     = 3'd6,
        STAT_RSVD    = 3'd7
    } stat_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } chan_state_e;

    // Adds a and b and clamps the result to the all-ones value of a
    // width-bit counter, so counters stick at their maximum instead of wrapping.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned width);
        logic [64:0] sum;
        logic [63:0] limit;
        limit = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        sum   = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, limit}) begin
            return limit;
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/ptw_chan_tracker.sv
// ptw_chan_tracker
// Passive observer for a single PTW requestor channel: tracks the one
// outstanding walk, measures its latency and accumulates statistics.
// Optional macro PTW_STATS_MONITOR_LOG_EN adds simulation-only logging of
// every completion and of each rising edge of the sticky error flags.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   clear                 zero counters and sticky flags (walk state kept)
//   req_valid/req_ready   request handshake, req_addr = VPN
//   resp_valid/ae/pte_v   response and its classification bits, resp_ppn
//   busy                  walk in flight
//   vpn                   current/last captured VPN
//   cnt_req..lat_sum      saturating statistics counters
//   lat_max               largest completed walk latency
//   timeout_err/proto_err sticky error flags
module ptw_chan_tracker
    import ptw_stats_pkg::*;
#(
    parameter int VPN_W   = 27,
    parameter int PPN_W   = 54,
    parameter int CNT_W   = 32,
    parameter int LAT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             req_valid,
    input  logic             req_ready,
    input  logic [VPN_W-1:0] req_addr,
    input  logic             resp_valid,
    input  logic             resp_ae,
    input  logic             resp_pte_v,
    input  logic [PPN_W-1:0] resp_ppn,
    output logic             busy,
    output logic [VPN_W-1:0] vpn,
    output logic [CNT_W-1:0] cnt_req,
    output logic [CNT_W-1:0] cnt_hit,
    output logic [CNT_W-1:0] cnt_miss,
    output logic [CNT_W-1:0] cnt_ae,
    output logic [CNT_W-1:0] lat_sum,
    output logic [LAT_W-1:0] lat_max,
    output logic             timeout_err,
    output logic             proto_err
);

    localparam logic [LAT_W-1:0] TIMEOUT_L = LAT_W'(TIMEOUT);

    chan_state_e      state;
    chan_state_e      state_next;
    logic [LAT_W-1:0] lat;
    logic [LAT_W-1:0] lat_inc;
    logic             accept;
    logic             complete;
    logic             stray_resp;
    logic             overwrite;

    assign accept     = req_valid & req_ready;
    assign complete   = (state == BUSY) & resp_valid;
    assign stray_resp = (state == IDLE) & resp_valid;
    assign overwrite  = (state == BUSY) & accept & ~resp_valid;
    assign busy       = (state == BUSY);

    // lat holds (cycles since accept - 1), so lat_inc is the latency a
    // response arriving this cycle would record; it saturates at all-ones.
    assign lat_inc = (&lat) ? lat : lat + LAT_W'(1);

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] x,
                                              input logic [CNT_W-1:0] y);
        return CNT_W'(sat_add(64'(x), 64'(y), CNT_W));
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A response with a same-cycle accept keeps the channel BUSY so the
    // next walk starts immediately.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = BUSY;
            BUSY: if (resp_valid && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // clear wipes statistics and flags but leaves vpn/lat alone so an
    // in-flight walk still completes with its true latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vpn         <= '0;
            lat         <= '0;
            cnt_req     <= '0;
            cnt_hit     <= '0;
            cnt_miss    <= '0;
            cnt_ae      <= '0;
            lat_sum     <= '0;
            lat_max     <= '0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            if (accept) begin
                vpn <= req_addr;
                lat <= '0;
            end else if (state == BUSY) begin
                lat <= lat_inc;
            end

            if (clear) begin
                cnt_req     <= '0;
                cnt_hit     <= '0;
                cnt_miss    <= '0;
                cnt_ae      <= '0;
                lat_sum     <= '0;
                lat_max     <= '0;
                timeout_err <= 1'b0;
                proto_err   <= 1'b0;
            end else begin
                if (accept) begin
                    cnt_req <= bump(cnt_req, CNT_W'(1));
                end
                if (complete) begin
                    if (resp_ae) begin
                        cnt_ae <= bump(cnt_ae, CNT_W'(1));
                    end else if (!resp_pte_v) begin
                        cnt_miss <= bump(cnt_miss, CNT_W'(1));
                    end else begin
                        cnt_hit <= bump(cnt_hit, CNT_W'(1));
                    end
                    lat_sum <= bump(lat_sum, CNT_W'(lat_inc));
                    if (lat_inc > lat_max) begin
                        lat_max <= lat_inc;
                    end
                end
                if (stray_resp || overwrite) begin
                    proto_err <= 1'b1;
                end
                if ((state == BUSY) && !resp_valid && !accept && (lat_inc >= TIMEOUT_L)) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

    logic unused_ppn;
    assign unused_ppn = ^resp_ppn;

`ifdef PTW_STATS_MONITOR_LOG_EN
`ifndef logI
`define logI(msg) $display("[INFO] %m: %s", msg)
`endif
    logic timeout_q;
    logic proto_q;

    always @(posedge clk) begin
        timeout_q <= timeout_err;
        proto_q   <= proto_err;
        if (rst_n && complete) begin
            if (resp_ae) begin
                `logI($sformatf("AE vpn=0x%0h", vpn));
            end else if (!resp_pte_v) begin
                `logI($sformatf("miss vpn=0x%0h", vpn));
            end else begin
                `logI($sformatf("hit vpn=0x%0h ppn[19:0]=0x%0h", vpn, 20'(resp_ppn)));
            end
        end
        if (timeout_err && !timeout_q) begin
            `logI("timeout_err raised");
        end
        if (proto_err && !proto_q) begin
            `logI("proto_err raised");
        end
    end
`endif

endmodule

// File: rtl/ptw_stats_monitor.sv
// ptw_stats_monitor
// Passive page-table-walker observer for NUM_REQ requestors. One
// ptw_chan_tracker per channel; this level unflattens the buses and
// provides a registered statistics readout.
// Optional macro PTW_STATS_MONITOR_LOG_EN enables simulation-only logging
// inside each channel tracker.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   clear                    zero counters and sticky flags
//   req_ready/req_valid      per-channel request handshake
//   req_addr                 flattened VPNs, channel i at [i*VPN_W +: VPN_W]
//   resp_valid/ae/pte_v/ppn  per-channel response (ppn flattened)
//   rd_req_sel, rd_stat_sel  readout channel / statistic select
//   rd_data                  registered readout, one cycle after select
//   outstanding              walk in flight per channel
//   timeout_err, proto_err   sticky per-channel error flags
module ptw_stats_monitor
    import ptw_stats_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int VPN_W   = 27,
    parameter int PPN_W   = 54,
    parameter int CNT_W   = 32,
    parameter int LAT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          clear,
    input  logic [NUM_REQ-1:0]                            req_ready,
    input  logic [NUM_REQ-1:0]                            req_valid,
    input  logic [NUM_REQ*VPN_W-1:0]                      req_addr,
    input  logic [NUM_REQ-1:0]                            resp_valid,
    input  logic [NUM_REQ-1:0]                            resp_ae,
    input  logic [NUM_REQ-1:0]                            resp_pte_v,
    input  logic [NUM_REQ*PPN_W-1:0]                      resp_ppn,
    input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rd_req_sel,
    input  logic [2:0]                                    rd_stat_sel,
    output logic [CNT_W-1:0]                              rd_data,
    output logic [NUM_REQ-1:0]                            outstanding,
    output logic [NUM_REQ-1:0]                            timeout_err,
    output logic [NUM_REQ-1:0]                            proto_err
);

    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [VPN_W-1:0] vpn      [NUM_REQ];
    logic [CNT_W-1:0] cnt_req  [NUM_REQ];
    logic [CNT_W-1:0] cnt_hit  [NUM_REQ];
    logic [CNT_W-1:0] cnt_miss [NUM_REQ];
    logic [CNT_W-1:0] cnt_ae   [NUM_REQ];
    logic [CNT_W-1:0] lat_sum  [NUM_REQ];
    logic [LAT_W-1:0] lat_max  [NUM_REQ];
    logic [CNT_W-1:0] rd_next;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_chan
        ptw_chan_tracker #(
            .VPN_W   (VPN_W),
            .PPN_W   (PPN_W),
            .CNT_W   (CNT_W),
            .LAT_W   (LAT_W),
            .TIMEOUT (TIMEOUT)
        ) u_tracker (
            .clk         (clk),
            .rst_n       (rst_n),
            .clear       (clear),
            .req_valid   (req_valid[i]),
            .req_ready   (req_ready[i]),
            .req_addr    (req_addr[i*VPN_W +: VPN_W]),
            .resp_valid  (resp_valid[i]),
            .resp_ae     (resp_ae[i]),
            .resp_pte_v  (resp_pte_v[i]),
            .resp_ppn    (resp_ppn[i*PPN_W +: PPN_W]),
            .busy        (outstanding[i]),
            .vpn         (vpn[i]),
            .cnt_req     (cnt_req[i]),
            .cnt_hit     (cnt_hit[i]),
            .cnt_miss    (cnt_miss[i]),
            .cnt_ae      (cnt_ae[i]),
            .lat_sum     (lat_sum[i]),
            .lat_max     (lat_max[i]),
            .timeout_err (timeout_err[i]),
            .proto_err   (proto_err[i])
        );
    end

    // Channel selects that match no tracker (rd_req_sel >= NUM_REQ) fall
    // through with the zero default.
    always_comb begin
        rd_next = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (SEL_W'(r) == rd_req_sel) begin
                unique case (stat_sel_e'(rd_stat_sel))
                    STAT_REQ:     rd_next = cnt_req[r];
                    STAT_HIT:     rd_next = cnt_hit[r];
                    STAT_MISS:    rd_next = cnt_miss[r];
                    STAT_AE:      rd_next = cnt_ae[r];
                    STAT_LAT_SUM: rd_next = lat_sum[r];
                    STAT_LAT_MAX: rd_next = CNT_W'(lat_max[r]);
                    STAT_VPN:     rd_next = CNT_W'(vpn[r]);
                    default:      rd_next = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_ptw_stats_monitor.sv
// tb_ptw_stats_monitor
// Directed bench for ptw_stats_monitor. The main instance has three channels
// and TIMEOUT=16; a second single-channel instance with 4-bit counters
// exercises saturation. Stimulus pushes hand-computed expectations into a
// scoreboard queue tagged with the cycle they become observable; a monitor
// on the falling edge pops and compares them.
module tb_ptw_stats_monitor;
    import ptw_stats_pkg::*;

    localparam int NREQ = 3;
    localparam int VW   = 27;
    localparam int PW   = 54;

    localparam int K_RD    = 0;
    localparam int K_RDSAT = 1;
    localparam int K_OUT   = 2;
    localparam int K_TO    = 3;
    localparam int K_PE    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               clear;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*VW-1:0] req_addr;
    logic [NREQ-1:0]    resp_valid;
    logic [NREQ-1:0]    resp_ae;
    logic [NREQ-1:0]    resp_pte_v;
    logic [NREQ*PW-1:0] resp_ppn;
    logic [1:0]         rd_req_sel;
    logic [2:0]         rd_stat_sel;
    logic [31:0]        rd_data;
    logic [NREQ-1:0]    outstanding;
    logic [NREQ-1:0]    timeout_err;
    logic [NREQ-1:0]    proto_err;

    logic               s_req_valid;
    logic [VW-1:0]      s_req_addr;
    logic               s_resp_valid;
    logic               s_resp_pte_v;
    logic               s_rd_req_sel;
    logic [2:0]         s_rd_stat_sel;
    logic [3:0]         s_rd_data;
    logic               s_outstanding;
    logic               s_timeout_err;
    logic               s_proto_err;

    ptw_stats_monitor #(
        .NUM_REQ (NREQ),
        .VPN_W   (VW),
        .PPN_W   (PW),
        .CNT_W   (32),
        .LAT_W   (16),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .req_ready   (req_ready),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .resp_valid  (resp_valid),
        .resp_ae     (resp_ae),
        .resp_pte_v  (resp_pte_v),
        .resp_ppn    (resp_ppn),
        .rd_req_sel  (rd_req_sel),
        .rd_stat_sel (rd_stat_sel),
        .rd_data     (rd_data),
        .outstanding (outstanding),
        .timeout_err (timeout_err),
        .proto_err   (proto_err)
    );

    ptw_stats_monitor #(
        .NUM_REQ (1),
        .VPN_W   (VW),
        .PPN_W   (PW),
        .CNT_W   (4),
        .LAT_W   (16),
        .TIMEOUT (1024)
    ) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (1'b0),
        .req_ready   (1'b1),
        .req_valid   (s_req_valid),
        .req_addr    (s_req_addr),
        .resp_valid  (s_resp_valid),
        .resp_ae     (1'b0),
        .resp_pte_v  (s_resp_pte_v),
        .resp_ppn    ({PW{1'b0}}),
        .rd_req_sel  (s_rd_req_sel),
        .rd_stat_sel (s_rd_stat_sel),
        .rd_data     (s_rd_data),
        .outstanding (s_outstanding),
        .timeout_err (s_timeout_err),
        .proto_err   (s_proto_err)
    );

    typedef struct {
        int          due;
        int          kind;
        int          ch;
        logic [63:0] expv;
        string       name;
    } sb_item_t;

    sb_item_t sbq[$];
    sb_item_t mon_item;
    logic [63:0] mon_act;
    int cyc     = 0;
    int n_check = 0;
    int n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose observation cycle has arrived.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            mon_item = sbq.pop_front();
            case (mon_item.kind)
                K_RD:    mon_act = 64'(rd_data);
                K_RDSAT: mon_act = 64'(s_rd_data);
                K_OUT:   mon_act = 64'(outstanding[mon_item.ch]);
                K_TO:    mon_act = 64'(timeout_err[mon_item.ch]);
                K_PE:    mon_act = 64'(proto_err[mon_item.ch]);
                default: mon_act = 'x;
            endcase
            n_check++;
            if (mon_act !== mon_item.expv) begin
                n_fail++;
                $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", mon_item.name, mon_act, mon_item.expv);
            end
        end
    end

    // One cycle: inputs set beforehand are sampled at the next edge, then
    // all single-cycle pulses are dropped.
    task automatic applyStimulus();
        @(posedge clk);
        #2;
        req_valid    = '0;
        resp_valid   = '0;
        resp_ae      = '0;
        resp_pte_v   = '0;
        clear        = 1'b0;
        s_req_valid  = 1'b0;
        s_resp_valid = 1'b0;
        s_resp_pte_v = 1'b0;
    endtask

    // Queue an expectation for the value visible after the coming edge.
    task automatic checkOutput(input int kind, input int ch, input int sel,
                               input logic [63:0] expv, input string name);
        sb_item_t it;
        it.due  = cyc + 1;
        it.kind = kind;
        it.ch   = ch;
        it.expv = expv;
        it.name = name;
        sbq.push_back(it);
        if (kind == K_RD) begin
            rd_req_sel  = 2'(ch);
            rd_stat_sel = 3'(sel);
        end else if (kind == K_RDSAT) begin
            s_rd_req_sel  = 1'(ch);
            s_rd_stat_sel = 3'(sel);
        end
    endtask

    task automatic readStat(input int ch, input stat_sel_e sel,
                            input logic [63:0] expv, input string name);
        checkOutput(K_RD, ch, int'(sel), expv, name);
        applyStimulus();
    endtask

    task automatic setReq(input int ch, input logic [VW-1:0] vpn);
        req_valid[ch]          = 1'b1;
        req_addr[ch*VW +: VW]  = vpn;
    endtask

    task automatic setResp(input int ch, input logic ae, input logic pte_v,
                           input logic [PW-1:0] ppn);
        resp_valid[ch]         = 1'b1;
        resp_ae[ch]            = ae;
        resp_pte_v[ch]         = pte_v;
        resp_ppn[ch*PW +: PW]  = ppn;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        req_ready = '1; req_valid = '0; req_addr = '0;
        resp_valid = '0; resp_ae = '0; resp_pte_v = '0; resp_ppn = '0;
        rd_req_sel = '0; rd_stat_sel = '0;
        s_req_valid = 1'b0; s_req_addr = '0; s_resp_valid = 1'b0; s_resp_pte_v = 1'b0;
        s_rd_req_sel = 1'b0; s_rd_stat_sel = '0;
        @(posedge clk); #2;
        applyStimulus();
        checkOutput(K_RD, 0, int'(STAT_REQ), 0, "reset_rd");
        checkOutput(K_OUT, 0, 0, 0, "reset_out0");
        checkOutput(K_PE, 1, 0, 0, "reset_pe1");
        checkOutput(K_TO, 2, 0, 0, "reset_to2");
        applyStimulus();
        rst_n = 1'b1;

        // Saturation: 21 accepts and 20 latency-1 hits on 4-bit counters.
        s_req_valid = 1'b1; s_req_addr = 27'h42;
        applyStimulus();
        for (int i = 0; i < 20; i++) begin
            s_req_valid = 1'b1; s_resp_valid = 1'b1; s_resp_pte_v = 1'b1;
            applyStimulus();
        end
        checkOutput(K_RDSAT, 0, int'(STAT_HIT), 15, "sat_hit");      applyStimulus();
        checkOutput(K_RDSAT, 0, int'(STAT_REQ), 15, "sat_req");      applyStimulus();
        checkOutput(K_RDSAT, 0, int'(STAT_LAT_SUM), 15, "sat_sum");  applyStimulus();
        checkOutput(K_RDSAT, 0, int'(STAT_LAT_MAX), 1, "sat_max");   applyStimulus();

        // Ch0 hit with latency 5.
        setReq(0, 27'h1234);
        checkOutput(K_OUT, 0, 0, 1, "ch0_out_accept");
        applyStimulus();
        for (int i = 1; i < 5; i++) applyStimulus();
        setResp(0, 1'b0, 1'b1, 54'hABCDE);
        checkOutput(K_OUT, 0, 0, 0, "ch0_out_resp");
        applyStimulus();
        readStat(0, STAT_REQ, 1, "ch0_req");
        readStat(0, STAT_HIT, 1, "ch0_hit");
        readStat(0, STAT_MISS, 0, "ch0_miss");
        readStat(0, STAT_LAT_SUM, 5, "ch0_sum");
        readStat(0, STAT_LAT_MAX, 5, "ch0_max");
        readStat(0, STAT_VPN, 27'h1234, "ch0_vpn");

        // Ch1: miss (lat 2), AE (lat 3) with back-to-back accept.
        setReq(1, 27'h111); applyStimulus();
        applyStimulus();
        setResp(1, 1'b0, 1'b0, '0); applyStimulus();
        setReq(1, 27'h222); applyStimulus();
        applyStimulus();
        applyStimulus();
        setResp(1, 1'b1, 1'b1, '0); setReq(1, 27'h333);
        checkOutput(K_OUT, 1, 0, 1, "ch1_out_b2b");
        applyStimulus();
        readStat(1, STAT_REQ, 3, "ch1_req");
        readStat(1, STAT_MISS, 1, "ch1_miss");
        readStat(1, STAT_AE, 1, "ch1_ae");
        readStat(1, STAT_HIT, 0, "ch1_hit");
        readStat(1, STAT_LAT_SUM, 5, "ch1_sum");
        readStat(1, STAT_LAT_MAX, 3, "ch1_max");
        checkOutput(K_PE, 1, 0, 0, "ch1_pe");
        readStat(1, STAT_VPN, 27'h333, "ch1_vpn");
        setResp(1, 1'b0, 1'b1, '0); applyStimulus();

        // Ch0 protocol errors: stray response, then overwrite accept.
        setResp(0, 1'b0, 1'b1, 54'h1);
        checkOutput(K_PE, 0, 0, 1, "ch0_pe_stray");
        applyStimulus();
        readStat(0, STAT_HIT, 1, "ch0_hit_after_stray");
        readStat(0, STAT_LAT_SUM, 5, "ch0_sum_after_stray");
        setReq(0, 27'h55); applyStimulus();
        applyStimulus();
        setReq(0, 27'h66); applyStimulus();
        setResp(0, 1'b0, 1'b1, '0); applyStimulus();
        readStat(0, STAT_REQ, 3, "ch0_req_overwrite");
        readStat(0, STAT_HIT, 2, "ch0_hit_overwrite");
        readStat(0, STAT_LAT_SUM, 6, "ch0_sum_overwrite");
        readStat(0, STAT_VPN, 27'h66, "ch0_vpn_overwrite");

        // Ch2 timeout at 16 busy cycles, response at 20.
        setReq(2, 27'h7FF); applyStimulus();
        for (int k = 1; k < 20; k++) begin
            if (k == 15) checkOutput(K_TO, 2, 0, 0, "ch2_to_before");
            if (k == 16) checkOutput(K_TO, 2, 0, 1, "ch2_to_set");
            if (k == 19) checkOutput(K_OUT, 2, 0, 1, "ch2_out_still_busy");
            applyStimulus();
        end
        setResp(2, 1'b0, 1'b1, '0);
        checkOutput(K_OUT, 2, 0, 0, "ch2_out_done");
        applyStimulus();
        readStat(2, STAT_LAT_SUM, 20, "ch2_sum");
        checkOutput(K_TO, 2, 0, 1, "ch2_to_sticky");
        readStat(2, STAT_LAT_MAX, 20, "ch2_max");

        // Clear mid-walk on ch2; same-cycle accept on ch0 must not count.
        setReq(2, 27'h777); applyStimulus();
        applyStimulus();
        applyStimulus();
        clear = 1'b1; setReq(0, 27'h88);
        checkOutput(K_TO, 2, 0, 0, "clr_to2");
        checkOutput(K_PE, 0, 0, 0, "clr_pe0");
        checkOutput(K_OUT, 0, 0, 1, "clr_out0");
        applyStimulus();
        applyStimulus();
        applyStimulus();
        applyStimulus();
        setResp(2, 1'b0, 1'b1, '0); setResp(0, 1'b0, 1'b1, '0);
        applyStimulus();
        readStat(2, STAT_REQ, 0, "clr_ch2_req");
        readStat(2, STAT_HIT, 1, "clr_ch2_hit");
        readStat(2, STAT_LAT_SUM, 7, "clr_ch2_sum");
        readStat(2, STAT_LAT_MAX, 7, "clr_ch2_max");
        readStat(2, STAT_VPN, 27'h777, "clr_ch2_vpn");
        readStat(0, STAT_REQ, 0, "clr_ch0_req");
        readStat(0, STAT_LAT_SUM, 4, "clr_ch0_sum");
        readStat(1, STAT_MISS, 0, "clr_ch1_miss");

        // Out-of-range channel and reserved statistic read as zero.
        readStat(3, STAT_REQ, 0, "rd_sel_oob");
        readStat(2, STAT_RSVD, 0, "rd_stat_rsvd");

        // Reset mid-walk, then a late response is a protocol error.
        setReq(0, 27'h99);
        checkOutput(K_OUT, 0, 0, 1, "rst_out_before");
        applyStimulus();
        rst_n = 1'b0;
        checkOutput(K_OUT, 0, 0, 0, "rst_out_after");
        applyStimulus();
        rst_n = 1'b1;
        setResp(0, 1'b0, 1'b1, '0);
        checkOutput(K_PE, 0, 0, 1, "rst_late_resp_pe");
        applyStimulus();
        readStat(0, STAT_HIT, 0, "rst_ch0_hit");

        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        if (sbq.size() > 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: actual=%0d pending required=0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
